// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared types and constants for the instruction fetch stage
package if_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;
  localparam logic [31:0] PC_STEP       = 32'd4;
  localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/if_perf_counters.sv
// rtl/if_perf_counters.sv - fetched/killed response event counters, wrapping at 2^32
module if_perf_counters (
  input  logic        clk,
  input  logic        clear,
  input  logic        inc_fetched,
  input  logic        inc_killed,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_killed
);

  logic [31:0] fetched_q, fetched_d;
  logic [31:0] killed_q, killed_d;

  always_comb begin
    fetched_d = fetched_q + {31'd0, inc_fetched};
    killed_d  = killed_q + {31'd0, inc_killed};
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      fetched_q <= 32'd0;
      killed_q  <= 32'd0;
    end else begin
      fetched_q <= fetched_d;
      killed_q  <= killed_d;
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_killed  = killed_q;

endmodule

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch stage: PC, single-outstanding imem requests, IF/ID output
// Optional IF_PERF_CNT_EN adds perf_fetched/perf_killed counter outputs.
module if_fetch_unit
  import if_pkg::fetch_state_e;
  import if_pkg::S_IDLE;
  import if_pkg::S_REQ;
  import if_pkg::S_WAIT;
  import if_pkg::S_HOLD;
  import if_pkg::PC_STEP;
  import if_pkg::PC_ALIGN_MASK;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = if_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        clear,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] instr_if,
  output logic [31:0] pc_if,
  output logic [31:0] pc_plus4_if,
  output logic        if_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_killed
`endif
);

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  req_pc_q, req_pc_d;
  logic [31:0]  out_instr_q, out_instr_d;
  logic [31:0]  out_pc_q, out_pc_d;
  logic         out_valid_q, out_valid_d;
  logic         kill_q, kill_d;

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q     <= S_IDLE;
      fetch_pc_q  <= RESET_PC;
      req_pc_q    <= RESET_PC;
      out_instr_q <= NOP_INSTR;
      out_pc_q    <= RESET_PC;
      out_valid_q <= 1'b0;
      kill_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      req_pc_q    <= req_pc_d;
      out_instr_q <= out_instr_d;
      out_pc_q    <= out_pc_d;
      out_valid_q <= out_valid_d;
      kill_q      <= kill_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    req_pc_d    = req_pc_q;
    out_instr_d = out_instr_q;
    out_pc_d    = out_pc_q;
    out_valid_d = out_valid_q;
    kill_d      = kill_q;

    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (imem_req_ready) begin
          req_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + PC_STEP;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            out_instr_d = imem_rsp_data;
            out_pc_d    = req_pc_q;
            out_valid_d = 1'b1;
            state_d     = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (!stall) begin
          out_valid_d = 1'b0;
          state_d     = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Redirect overrides everything above; an in-flight request becomes wrong-path.
    if (redirect_valid) begin
      fetch_pc_d  = redirect_pc & PC_ALIGN_MASK;
      out_valid_d = 1'b0;
      case (state_q)
        S_REQ: begin
          if (imem_req_ready) kill_d = 1'b1;
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            state_d     = S_REQ;
            kill_d      = 1'b0;
            out_instr_d = out_instr_q;
            out_pc_d    = out_pc_q;
          end else begin
            kill_d = 1'b1;
          end
        end
        S_HOLD: state_d = S_REQ;
        default: ;
      endcase
    end
  end

  assign imem_req_valid = (state_q == S_REQ);
  assign imem_req_addr  = fetch_pc_q;
  assign instr_if       = out_valid_q ? out_instr_q : NOP_INSTR;
  assign pc_if          = out_pc_q;
  assign pc_plus4_if    = out_pc_q + PC_STEP;
  assign if_valid       = out_valid_q;

`ifdef IF_PERF_CNT_EN
  logic rsp_in_wait;
  logic fetched_evt;
  logic killed_evt;

  assign rsp_in_wait = (state_q == S_WAIT) && imem_rsp_valid;
  assign fetched_evt = rsp_in_wait && !kill_q && !redirect_valid;
  assign killed_evt  = rsp_in_wait && (kill_q || redirect_valid);

  if_perf_counters u_perf (
    .clk          (clk),
    .clear        (clear),
    .inc_fetched  (fetched_evt),
    .inc_killed   (killed_evt),
    .perf_fetched (perf_fetched),
    .perf_killed  (perf_killed)
  );
`endif

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction fetch stage. Owns the PC and issues word requests to instruction memory over a valid/ready request channel, then captures the responses. Presents {instr, pc, pc+4, valid} to the IF/ID pipeline register. Honours the stall used as the IF/ID enable, and redirects from EX, discarding in-flight wrong-path responses. At most one memory request is outstanding.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset (bits [1:0] must be 0).
NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0) driven when no valid instruction.

Ports:
clk  in  1  clock, rising edge
clear  in  1  asynchronous active-low reset
stall  in  1  1 = IF/ID not enabled this cycle; hold presented instruction
redirect_valid  in  1  taken branch/jump from EX
redirect_pc  in  32  redirect target; bits [1:0] ignored
imem_req_valid  out  1  request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  32  word address of request
imem_rsp_valid  in  1  response valid; always accepted, no backpressure
imem_rsp_data  in  32  instruction word
instr_if  out  32  instruction to IF/ID
pc_if  out  32  PC of instr_if
pc_plus4_if  out  32  pc_if + 4
if_valid  out  1  instr_if is a real instruction (0 = bubble)

Behaviour:
- State registers: state, fetch_pc, req_pc, out_instr, out_pc, out_valid, kill.
- FSM states: S_IDLE, S_REQ, S_WAIT, S_HOLD.
- Reset (clear low, async): state=S_IDLE, fetch_pc=RESET_PC, req_pc=RESET_PC, out_pc=RESET_PC, out_instr=NOP_INSTR, out_valid=0, kill=0.
- Reset output values: imem_req_valid=0, imem_req_addr=RESET_PC, instr_if=NOP_INSTR, pc_if=RESET_PC, pc_plus4_if=RESET_PC+4, if_valid=0.
- Reset mid-operation discards all state; a response arriving after clear deasserts while in S_IDLE/S_REQ is ignored.
- Output decode:
  - imem_req_valid = (state==S_REQ); imem_req_addr = fetch_pc.
  - instr_if = out_valid ? out_instr : NOP_INSTR; pc_if = out_pc; if_valid = out_valid.
  - pc_plus4_if = out_pc + 4, modulo 2^32.
- S_IDLE -> S_REQ unconditionally (first request at the 2nd edge after reset release).
- S_REQ: on imem_req_ready, req_pc<=fetch_pc, fetch_pc<=fetch_pc+4 (wraps 32'hFFFF_FFFC -> 0), go to S_WAIT.
- S_WAIT: on imem_rsp_valid:
  - kill=1: drop the response, kill<=0, go to S_REQ.
  - kill=0: out_instr<=data, out_pc<=req_pc, out_valid<=1, go to S_HOLD.
- S_HOLD: if stall=0, IF/ID captures the instruction this edge; out_valid<=0, go to S_REQ. If stall=1, hold all outputs unchanged.
- Redirect has highest priority in every state; fetch_pc<={redirect_pc[31:2],2'b00}, out_valid<=0.
  - S_IDLE: no other effect (S_IDLE -> S_REQ still applies).
  - S_REQ without handshake: stay in S_REQ.
  - S_REQ with same-cycle handshake: go to S_WAIT with kill<=1.
  - S_WAIT, no rsp this cycle: kill<=1.
  - S_WAIT, rsp same cycle: drop the response, go to S_REQ, kill<=0.
  - S_HOLD: go to S_REQ, regardless of stall.
- stall outside S_HOLD has no effect. imem_rsp_valid outside S_WAIT is ignored.
- Latency: request accept to if_valid = response latency + 1 edge.

Optional Feature:
IF_PERF_CNT_EN: when defined, adds outputs perf_fetched[31:0] (+1 per response captured in S_HOLD) and perf_killed[31:0] (+1 per response dropped through kill or same-cycle redirect). Both reset to 0 and wrap at 2^32. When undefined, these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package if_pkg: fetch_state_e enum {S_IDLE,S_REQ,S_WAIT,S_HOLD}, NOP_INSTR constant, PC_STEP=32'd4.
- Sub-module if_perf_counters (two saturating-free wrap counters), instantiated only under IF_PERF_CNT_EN. FSM and datapath stay in if_fetch_unit.

Test Plan:
- Reset release, ready=1, 1-cycle memory: imem_req_addr sequence 0x0,0x4,0x8; if_valid pulses with pc_if=0x0,0x4; pc_plus4_if=0x4,0x8.
- stall=1 for 3 cycles while in S_HOLD with pc_if=0x8: instr_if/pc_if stable, no new request; stall drop -> next request addr 0xC.
- Redirect to 0x100 while in S_WAIT for 0x10, response 2 cycles later: response dropped, if_valid stays 0, next request 0x100; perf_killed=1.
- Redirect same cycle as rsp_valid, and redirect same cycle as request handshake: both old responses dropped; next if_valid has pc_if=redirect target.
- redirect_pc=0x203 -> request addr 0x200. fetch_pc=0xFFFF_FFFC -> next request addr 0x0; pc_plus4_if=0x0.
- Assert clear mid S_WAIT, release, then deliver a stale rsp_valid: ignored; fetch restarts at RESET_PC with if_valid=0 throughout reset.
